serial_digit_adder: RTL

SERIAL_DIGIT_ADDER -- requirements
Module: serial_digit_adder

---
 rtl/serial_digit_adder.sv | 133 +++++++++++++
 1 files changed

// File: rtl/serial_digit_adder.sv
//==============================================================================
// Module      : serial_digit_adder
// Description : Digit-serial unsigned adder. It accepts a, b and ci through a
//               valid/ready handshake, adds DIGIT bits per cycle LSB-first,
//               and holds {co,s} in DONE until the consumer takes the result.
//               Optional subtract mode (a + ~b + 1) is enabled by defining
//               the macro SERIAL_DIGIT_ADDER_SUB_EN, which adds a 'sub' input.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module serial_digit_adder #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
`ifdef SERIAL_DIGIT_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             co
);

    localparam int c_ndig = WIDTH / DIGIT;
    localparam int c_cw   = (c_ndig > 1) ? $clog2(c_ndig) : 1;
    localparam logic [c_cw-1:0] c_last = c_cw'(c_ndig - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic               r_carry;
    logic [c_cw-1:0]    r_cnt;
    // Set once the final digit has been written; the following RUN edge
    // moves to DONE, giving WIDTH/DIGIT+1 cycles from acceptance to out_valid.
    logic               r_fin;

    logic [DIGIT-1:0]   w_a_dig;
    logic [DIGIT-1:0]   w_b_dig;
    logic [DIGIT:0]     w_sum;
    logic [WIDTH-1:0]   w_b_in;
    logic               w_c_in;

    // Operand preparation at acceptance: subtract folds into an add of ~b
    // with a forced carry-in, so the serial datapath is shared.
`ifdef SERIAL_DIGIT_ADDER_SUB_EN
    assign w_b_in = sub ? ~b : b;
    assign w_c_in = sub ? 1'b1 : ci;
`else
    assign w_b_in = b;
    assign w_c_in = ci;
`endif

    // Current digit slice and its (DIGIT+1)-bit sum including the carry.
    assign w_a_dig = r_a[r_cnt*DIGIT +: DIGIT];
    assign w_b_dig = r_b[r_cnt*DIGIT +: DIGIT];
    assign w_sum   = {1'b0, w_a_dig} + {1'b0, w_b_dig} + {{DIGIT{1'b0}}, r_carry};

    // Control FSM and datapath registers; reset overrides every handshake.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_a       <= '0;
            r_b       <= '0;
            r_carry   <= 1'b0;
            r_cnt     <= '0;
            r_fin     <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            s         <= '0;
            co        <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        r_a      <= a;
                        r_b      <= w_b_in;
                        r_carry  <= w_c_in;
                        r_cnt    <= '0;
                        r_fin    <= 1'b0;
                        in_ready <= 1'b0;
                        r_state  <= RUN;
                    end
                end
                RUN: begin
                    if (!r_fin) begin
                        s[r_cnt*DIGIT +: DIGIT] <= w_sum[DIGIT-1:0];
                        r_carry                 <= w_sum[DIGIT];
                        if (r_cnt == c_last) begin
                            co    <= w_sum[DIGIT];
                            r_fin <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end else begin
                        out_valid <= 1'b1;
                        r_state   <= DONE;
                    end
                end
                DONE: begin
                    // in_ready rises only with the return to IDLE, so no
                    // operand can be accepted on the completing edge.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        r_state   <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    r_state   <= IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire
